// File: rtl/alu_issue_ctrl.sv
// Single-issue controller: fetches one instruction, reads the register file,
// drives an external combinational ALU and writes the result back.
module alu_issue_ctrl #(
  parameter int unsigned ZERO_REG = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic [4:0]  alu_shamt,
  output logic [5:0]  alu_opcode,
  output logic [15:0] alu_constant,
  input  logic [31:0] alu_ans,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] alu_in1_q, alu_in1_d;
  logic [31:0] alu_in2_q, alu_in2_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [5:0]  alu_opcode_q, alu_opcode_d;
  logic [15:0] alu_constant_q, alu_constant_d;
  logic [4:0]  dest_q, dest_d;
  logic [31:0] ans_q, ans_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [5:0]  f_opcode;
  logic [4:0]  f_rs, f_rt, f_rd, f_shamt;
  logic [15:0] f_imm;
  logic [31:0] rs_val, rt_val;
  logic        r_type, legal;

  assign f_opcode = instr_q[31:26];
  assign f_rs     = instr_q[25:21];
  assign f_rt     = instr_q[20:16];
  assign f_rd     = instr_q[15:11];
  assign f_shamt  = instr_q[10:6];
  assign f_imm    = instr_q[15:0];
  assign r_type   = (f_opcode < 6'd6);
  assign legal    = (f_opcode < 6'd8);

  // Register 0 is never written when ZERO_REG is set; the read mask keeps it
  // hard-wired regardless of reset history.
  assign rs_val   = (ZERO_REG != 0 && f_rs == 5'd0) ? '0 : rf_q[f_rs];
  assign rt_val   = (ZERO_REG != 0 && f_rt == 5'd0) ? '0 : rf_q[f_rt];
  assign dbg_data = (ZERO_REG != 0 && dbg_addr == 5'd0) ? '0 : rf_q[dbg_addr];

  assign instr_ready  = (state_q == IDLE);
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_shamt    = alu_shamt_q;
  assign alu_opcode   = alu_opcode_q;
  assign alu_constant = alu_constant_q;
  assign done         = done_q;
  assign err          = err_q;
  assign result       = result_q;

  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    alu_in1_d      = alu_in1_q;
    alu_in2_d      = alu_in2_q;
    alu_shamt_d    = alu_shamt_q;
    alu_opcode_d   = alu_opcode_q;
    alu_constant_d = alu_constant_q;
    dest_d         = dest_q;
    ans_d          = ans_q;
    result_d       = result_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    rf_d           = rf_q;
    unique case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!legal) begin
          done_d   = 1'b1;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = IDLE;
        end else begin
          // The operand registers are the ALU outputs, so they only move on
          // entry to EXEC and hold everywhere else.
          alu_in1_d      = rs_val;
          alu_in2_d      = r_type ? rt_val : '0;
          alu_shamt_d    = f_shamt;
          alu_opcode_d   = f_opcode;
          alu_constant_d = f_imm;
          dest_d         = r_type ? f_rd : f_rt;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        ans_d   = alu_ans;
        state_d = WB;
      end
      WB: begin
        if (!(ZERO_REG != 0 && dest_q == 5'd0)) rf_d[dest_q] = ans_q;
        result_d = ans_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      instr_q        <= '0;
      alu_in1_q      <= '0;
      alu_in2_q      <= '0;
      alu_shamt_q    <= '0;
      alu_opcode_q   <= '0;
      alu_constant_q <= '0;
      dest_q         <= '0;
      ans_q          <= '0;
      result_q       <= '0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      rf_q           <= '{default: '0};
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      alu_in1_q      <= alu_in1_d;
      alu_in2_q      <= alu_in2_d;
      alu_shamt_q    <= alu_shamt_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_constant_q <= alu_constant_d;
      dest_q         <= dest_d;
      ans_q          <= ans_d;
      result_q       <= result_d;
      done_q         <= done_d;
      err_q          <= err_d;
      rf_q           <= rf_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: external ALU model, vector table with a result
// scoreboard, plus hand-written reset sequences.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_in1, alu_in2;
  logic [4:0]  alu_shamt;
  logic [5:0]  alu_opcode;
  logic [15:0] alu_constant;
  logic [31:0] alu_ans;
  logic        done;
  logic [31:0] result;
  logic        err;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  alu_issue_ctrl #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_shamt(alu_shamt), .alu_opcode(alu_opcode), .alu_constant(alu_constant),
    .alu_ans(alu_ans), .done(done), .result(result), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 0 add, 1 sll, 2 srl, 3 or, 4 and, 5 sub, 6 addi, 7 li
  always_comb begin
    alu_ans = '0;
    case (alu_opcode)
      6'd0: alu_ans = alu_in1 + alu_in2;
      6'd1: alu_ans = alu_in1 << alu_shamt;
      6'd2: alu_ans = alu_in1 >> alu_shamt;
      6'd3: alu_ans = alu_in1 | alu_in2;
      6'd4: alu_ans = alu_in1 & alu_in2;
      6'd5: alu_ans = alu_in1 - alu_in2;
      6'd6: alu_ans = alu_in1 + {{16{alu_constant[15]}}, alu_constant};
      6'd7: alu_ans = {16'd0, alu_constant};
      default: alu_ans = '0;
    endcase
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_res;
    logic        exp_err;
    logic [4:0]  chk_addr;
    logic [31:0] exp_dbg;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh);
    return {op, rs, rt, rd, sh, 6'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge; returns at the negedge of the done cycle (+1).
  task automatic run_vec(input vec_t v);
    exp_t e;
    int unsigned lat;
    logic got;
    logic [5:0] op;
    op = v.instr[31:26];
    instr = v.instr;
    instr_valid = 1'b1;
    sb.push_back('{res: v.exp_res, err: v.exp_err});
    #1 chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    @(posedge clk);
    #1 instr = {6'd40, 26'd0};  // junk held valid while busy; must be ignored
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) got = 1'b1;
    end
    instr_valid = 1'b0;
    if (!got) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end else begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("err", {31'd0, err}, {31'd0, e.err});
      end
      chk("latency", lat, v.exp_err ? 32'd2 : 32'd4);
      chk("ready_in_done_cycle", {31'd0, instr_ready}, 32'd1);
      if (!v.exp_err) chk("alu_opcode_held", {26'd0, alu_opcode}, {26'd0, op});
      dbg_addr = v.chk_addr;
      #1 chk("dbg_data", dbg_data, v.exp_dbg);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0]  = '{enc_i(6'd7, 5'd0, 5'd3, 16'h1234), 32'h0000_1234, 1'b0, 5'd3, 32'h0000_1234};
    vecs[1]  = '{enc_i(6'd7, 5'd0, 5'd3, 16'h0005), 32'd5, 1'b0, 5'd3, 32'd5};
    vecs[2]  = '{enc_i(6'd7, 5'd0, 5'd4, 16'h0007), 32'd7, 1'b0, 5'd4, 32'd7};
    vecs[3]  = '{enc_r(6'd0, 5'd3, 5'd4, 5'd5, 5'd0), 32'd12, 1'b0, 5'd5, 32'd12};
    vecs[4]  = '{enc_r(6'd3, 5'd3, 5'd4, 5'd6, 5'd0), 32'd7, 1'b0, 5'd6, 32'd7};
    vecs[5]  = '{enc_i(6'd7, 5'd0, 5'd3, 16'h0001), 32'd1, 1'b0, 5'd3, 32'd1};
    vecs[6]  = '{enc_r(6'd1, 5'd3, 5'd0, 5'd7, 5'd31), 32'h8000_0000, 1'b0, 5'd7, 32'h8000_0000};
    vecs[7]  = '{enc_r(6'd2, 5'd7, 5'd0, 5'd8, 5'd31), 32'd1, 1'b0, 5'd8, 32'd1};
    vecs[8]  = '{enc_r(6'd9, 5'd3, 5'd4, 5'd5, 5'd0), 32'd0, 1'b1, 5'd5, 32'd12};
    vecs[9]  = '{enc_i(6'd7, 5'd0, 5'd0, 16'hBEEF), 32'h0000_BEEF, 1'b0, 5'd0, 32'd0};
    vecs[10] = '{enc_i(6'd6, 5'd5, 5'd9, 16'hFFFF), 32'd11, 1'b0, 5'd9, 32'd11};
    vecs[11] = '{enc_r(6'd5, 5'd4, 5'd3, 5'd10, 5'd0), 32'd6, 1'b0, 5'd10, 32'd6};
    vecs[12] = '{enc_r(6'd4, 5'd5, 5'd4, 5'd11, 5'd0), 32'd4, 1'b0, 5'd11, 32'd4};
    vecs[13] = '{enc_r(6'd0, 5'd5, 5'd4, 5'd0, 5'd0), 32'd19, 1'b0, 5'd0, 32'd0};
    vecs[14] = '{enc_r(6'd63, 5'd5, 5'd4, 5'd11, 5'd0), 32'd0, 1'b1, 5'd11, 32'd4};

    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    dbg_addr = 5'd3;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_alu_in1", alu_in1, 32'd0);
    chk("rst_alu_ctl", {11'd0, alu_shamt, alu_opcode, alu_constant}, 32'd0);
    chk("rst_dbg", dbg_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);

    // Reset during EXEC of add R5 = R3 + R4 (1 + 7)
    instr = enc_r(6'd0, 5'd3, 5'd4, 5'd5, 5'd0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("exec_alu_in1", alu_in1, 32'd1);
    chk("exec_alu_in2", alu_in2, 32'd7);
    rst = 1'b1;
    dbg_addr = 5'd5;
    #1;
    chk("midrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("midrst_dbg_r5", dbg_data, 32'd0);
    chk("midrst_alu_in1", alu_in1, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    dbg_addr = 5'd4;
    #1 chk("midrst_dbg_r4", dbg_data, 32'd0);
    @(negedge clk);
    run_vec('{enc_i(6'd7, 5'd0, 5'd5, 16'h0042), 32'h0000_0042, 1'b0, 5'd5, 32'h0000_0042});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
